wb_arbbus: RTL and testbench

//   Parametrised shared-bus Wishbone interconnect: N masters, M slaves, single active transfer.

---
 rtl/wb_arbbus.sv | 162 ++++++++++++++++
 tb/tb_wb_arbbus.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbbus.sv
// rtl/wb_arbbus.sv - Shared-bus Wishbone interconnect: round-robin masters, address-decoded slaves.
// Unmapped addresses and silent slaves both end in a one-cycle error on the owner lane.
module wb_arbbus #(
    parameter int                           N_MASTERS      = 2,
    parameter int                           N_SLAVES       = 6,
    parameter int                           S_ADDR_W       = 3,
    parameter logic [N_SLAVES*S_ADDR_W-1:0] S_ADDR         = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
    parameter int                           TIMEOUT_CYCLES = 255
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [32*N_MASTERS-1:0]  m_adr_i,
    input  logic [32*N_MASTERS-1:0]  m_dat_i,
    input  logic [4*N_MASTERS-1:0]   m_sel_i,
    input  logic [N_MASTERS-1:0]     m_we_i,
    input  logic [N_MASTERS-1:0]     m_cyc_i,
    input  logic [N_MASTERS-1:0]     m_stb_i,
    output logic [32*N_MASTERS-1:0]  m_dat_o,
    output logic [N_MASTERS-1:0]     m_ack_o,
    output logic [N_MASTERS-1:0]     m_err_o,
    output logic [32*N_SLAVES-1:0]   s_adr_o,
    output logic [32*N_SLAVES-1:0]   s_dat_o,
    output logic [4*N_SLAVES-1:0]    s_sel_o,
    output logic [N_SLAVES-1:0]      s_we_o,
    output logic [N_SLAVES-1:0]      s_cyc_o,
    output logic [N_SLAVES-1:0]      s_stb_o,
    input  logic [32*N_SLAVES-1:0]   s_dat_i,
    input  logic [N_SLAVES-1:0]      s_ack_i
);
    localparam int MW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [MW-1:0]  owner_q, owner_d, last_q, last_d, rr_pick;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           unm_err_q, unm_err_d, err_hold_q;

    logic           busy, own_we, own_cyc, own_stb, active;
    logic [31:0]    own_adr, own_dat, rdata;
    logic [3:0]     own_sel;
    logic [SW-1:0]  sel_idx;
    logic           any_hit, mapped, ack_raw, expire, wd_err;

    assign busy = (state_q == BUSY);

    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (busy) begin
            own_adr = m_adr_i[owner_q*32 +: 32];
            own_dat = m_dat_i[owner_q*32 +: 32];
            own_sel = m_sel_i[owner_q*4 +: 4];
            own_we  = m_we_i[owner_q];
            own_cyc = m_cyc_i[owner_q];
            own_stb = m_stb_i[owner_q];
        end
    end

    // Scan downwards so the lowest matching slave index is the one left standing.
    always_comb begin
        sel_idx = '0;
        any_hit = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (own_adr[31 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W]) begin
                sel_idx = SW'(i);
                any_hit = 1'b1;
            end
        end
    end

    assign mapped  = busy & any_hit;
    assign ack_raw = mapped & s_ack_i[sel_idx];
    assign rdata   = mapped ? s_dat_i[sel_idx*32 +: 32] : 32'h0;
    assign active  = busy & own_cyc & own_stb;
    // Expiry does not look at ack, so forcing the strobe low cannot loop through a combinational slave.
    assign expire  = (TIMEOUT_CYCLES > 0) && active && (wdog_q == WD_LAST);
    assign wd_err  = expire & ~ack_raw;

    always_comb begin
        rr_pick = last_q;
        for (int k = N_MASTERS; k >= 1; k--) begin
            if (m_cyc_i[(int'(last_q) + k) % N_MASTERS]) begin
                rr_pick = MW'((int'(last_q) + k) % N_MASTERS);
            end
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        s_cyc_o = '0;
        s_stb_o = '0;
        if (busy) begin
            m_ack_o[owner_q] = ack_raw;
            m_err_o[owner_q] = wd_err | unm_err_q;
            if (mapped && !expire) begin
                s_cyc_o[sel_idx] = own_cyc;
                s_stb_o[sel_idx] = own_stb;
            end
        end
    end

    assign m_dat_o = {N_MASTERS{rdata}};
    assign s_adr_o = {N_SLAVES{own_adr}};
    assign s_dat_o = {N_SLAVES{own_dat}};
    assign s_sel_o = {N_SLAVES{own_sel}};
    assign s_we_o  = {N_SLAVES{own_we}};

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wdog_d    = '0;
        unm_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d = BUSY;
                    owner_d = rr_pick;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    owner_d = '0;
                end
                unm_err_d = active & ~any_hit & ~unm_err_q & ~err_hold_q;
                if ((TIMEOUT_CYCLES > 0) && active && !ack_raw && !expire) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= MW'(N_MASTERS - 1);
            wdog_q     <= '0;
            unm_err_q  <= 1'b0;
            err_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            unm_err_q  <= unm_err_d;
            err_hold_q <= unm_err_q;
        end
    end
endmodule

// File: tb/tb_wb_arbbus.sv
// tb/tb_wb_arbbus.sv - Directed and randomized bench for wb_arbbus against a round-robin/decode model.
module tb_wb_arbbus;
    localparam int NM = 2;
    localparam int NS = 6;
    localparam int TO = 8;

    logic              clk, rst;
    logic [NM*32-1:0]  m_adr, m_dat_w, m_dat_o;
    logic [NM*4-1:0]   m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb, m_ack_o, m_err_o;
    logic [NS*32-1:0]  s_adr_o, s_dat_o, s_dat;
    logic [NS*4-1:0]   s_sel_o;
    logic [NS-1:0]     s_we_o, s_cyc_o, s_stb_o, s_ack;

    int checks = 0;
    int errors = 0;
    int last;

    wb_arbbus #(
        .N_MASTERS(NM), .N_SLAVES(NS), .S_ADDR_W(3),
        .S_ADDR({3'b110, 3'b101, 3'b100, 3'b011, 3'b001, 3'b111}),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(clk), .sys_rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slave_of(input logic [31:0] a);
        case (a[31:29])
            3'b111:  return 0;
            3'b001:  return 1;
            3'b011:  return 2;
            3'b100:  return 3;
            3'b101:  return 4;
            3'b110:  return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [NS-1:0] oh(input int s);
        logic [NS-1:0] v;
        v = '0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input int lst, input logic [NM-1:0] req);
        for (int k = 1; k <= NM; k++) begin
            if (req[(lst + k) % NM]) return (lst + k) % NM;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_m(input int m, input logic [31:0] adr, input bit we);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m]  = we;
        m_adr[m*32 +: 32]   = adr;
        m_dat_w[m*32 +: 32] = $urandom;
        m_sel[m*4 +: 4]     = 4'hF;
    endtask

    // Called in the cycle the requests are first visible on an idle bus.
    task automatic xfer(input int w, input int lat, input logic [31:0] rd);
        int sl;
        logic [NM-1:0] wl;
        sl = slave_of(m_adr[w*32 +: 32]);
        wl = '0;
        wl[w] = 1'b1;
        samp();
        check("idle_stb", s_stb_o, '0);
        if (sl >= 0) begin
            for (int k = 0; k <= lat; k++) begin
                step();
                if (k == lat) begin
                    s_ack[sl] = 1'b1;
                    s_dat[sl*32 +: 32] = rd;
                end
                samp();
                check("sel_stb", s_stb_o, oh(sl));
                check("sel_cyc", s_cyc_o, oh(sl));
                check("ack", m_ack_o, (k == lat) ? wl : '0);
                check("err", m_err_o, '0);
                if (k == lat) check("rdata", m_dat_o, {rd, rd});
            end
            step();
            s_ack = '0;
        end else begin
            step();
            samp();
            check("unm_stb", s_stb_o, '0);
            check("unm_err0", m_err_o, '0);
            step();
            samp();
            check("unm_pulse", m_err_o, wl);
            step();
            samp();
            check("unm_hold", m_err_o, '0);
            step();
        end
        m_cyc[w] = 1'b0;
        m_stb[w] = 1'b0;
        samp();
        check("release_stb", s_stb_o, '0);
    endtask

    task automatic arb_xfer(input int lat, input logic [31:0] rd);
        int w;
        w = pick(last, m_cyc);
        xfer(w, lat, rd);
        last = w;
    endtask

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_ack = '0;
        for (int i = 0; i < NS; i++) s_dat[i*32 +: 32] = $urandom;
        last = NM - 1;
        samp();
        check("rst_ack", m_ack_o, '0);
        check("rst_err", m_err_o, '0);
        check("rst_stb", s_stb_o, '0);
        check("rst_cyc", s_cyc_o, '0);
        check("rst_dat", m_dat_o, '0);

        step(); rst = 1'b0;
        set_m(0, 32'h2000_0004, 1'b0);
        arb_xfer(2, 32'hDEAD_BEEF);

        step(); rst = 1'b1; step(); rst = 1'b0;
        last = NM - 1;
        set_m(0, 32'h6000_0000, 1'b0);
        set_m(1, 32'h8000_0010, 1'b1);
        arb_xfer(1, $urandom);
        step();
        arb_xfer(0, $urandom);

        for (int i = 0; i < 6; i++) begin
            step();
            for (int m = 0; m < NM; m++) begin
                if (!m_cyc[m]) set_m(m, 32'hA000_0000 + 32'(i*4), 1'b0);
            end
            arb_xfer(0, $urandom);
        end

        step();
        m_cyc = '0; m_stb = '0;
        set_m(1, 32'h1000_0000, 1'b1);
        arb_xfer(0, '0);

        step();
        set_m(0, 32'h6000_0010, 1'b0);
        samp();
        check("wd_idle", s_stb_o, '0);
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            samp();
            check("wd_stb", s_stb_o, (k == TO) ? '0 : oh(2));
            check("wd_err", m_err_o, (k == TO) ? 2'b01 : 2'b00);
        end
        step();
        m_cyc = '0; m_stb = '0;
        step();
        set_m(0, 32'h6000_0020, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            step();
            if (k == TO) begin
                s_ack[2] = 1'b1;
                s_dat[2*32 +: 32] = 32'h0BAD_F00D;
            end
            samp();
            check("wdack_ack", m_ack_o, (k == TO) ? 2'b01 : 2'b00);
            check("wdack_err", m_err_o, '0);
        end
        step();
        s_ack = '0; m_cyc = '0; m_stb = '0;
        last = 0;

        step();
        set_m(0, 32'h8000_0000, 1'b0);
        samp();
        step();
        s_ack[3] = 1'b1;
        s_dat[3*32 +: 32] = 32'hA5A5_0003;
        samp();
        check("pre_rst_stb", s_stb_o, oh(3));
        check("pre_rst_ack", m_ack_o, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("arst_stb", s_stb_o, '0);
        check("arst_cyc", s_cyc_o, '0);
        check("arst_ack", m_ack_o, '0);
        check("arst_err", m_err_o, '0);
        check("arst_dat", m_dat_o, '0);
        step(); step();
        rst = 1'b0; s_ack = '0; m_cyc = '0; m_stb = '0;
        last = NM - 1;
        set_m(1, 32'hA000_0000, 1'b0);
        arb_xfer(1, $urandom);
        step(); rst = 1'b1; step(); rst = 1'b0;
        last = NM - 1;
        set_m(0, 32'hC000_0000, 1'b0);
        set_m(1, 32'hE000_0000, 1'b0);
        arb_xfer(0, $urandom);
        step();
        arb_xfer(1, $urandom);

        for (int i = 0; i < 16; i++) begin
            logic [NM-1:0] req;
            step();
            m_cyc = '0; m_stb = '0;
            req = NM'($urandom_range(1, (1 << NM) - 1));
            for (int m = 0; m < NM; m++) begin
                if (req[m]) set_m(m, $urandom, 1'($urandom));
            end
            arb_xfer($urandom_range(0, 3), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
